run_detector: RTL and testbench
===============================

RUN_DETECTOR -- requirements
Module: run_detector

Interface
REQ-001 Parameter RUN_LEN, default 4, SHALL set the run length (consecutive equal samples) that asserts z; legal range 2..255.
REQ-002 Parameter CNT_W, default 8, SHALL set the detection-counter width; legal range 1..32.
REQ-003 Derived width RL_W SHALL be $clog2(RUN_LEN+1).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 en  input  1  SHALL qualify sampling of w; w is ignored when en=0.
REQ-007 w  input  1  SHALL be the serial data bit under observation.
REQ-008 mode  input  2  SHALL select detection: 00 both polarities, 01 ones only, 10 zeros only, 11 same as 00.
REQ-009 z  output  1  SHALL flag that a qualifying run is in progress.
REQ-010 run_len  output  RL_W  SHALL expose the current saturated run count.
REQ-011 last_bit  output  1  SHALL expose the most recently sampled w.
REQ-012 det_count  output  CNT_W  SHALL count detections (present only per REQ-027).

Function
REQ-013 State SHALL be run (RL_W bits, 0..RUN_LEN) and last (1 bit); run=0 means no sample since reset.
REQ-014 On a clk edge with en=1 and run=0: run<=1, last<=w.
REQ-015 On a clk edge with en=1, run>0, w==last: run<=min(run+1, RUN_LEN), last unchanged.
REQ-016 On a clk edge with en=1, run>0, w!=last: run<=1, last<=w.
REQ-017 On a clk edge with en=0, run and last SHALL hold.
REQ-018 z SHALL be Moore/combinational from state and mode: z = (run==RUN_LEN) AND (mode allows polarity last).
REQ-019 Latency: z SHALL assert in the cycle after the edge that captures the RUN_LEN-th consecutive equal qualified sample.
REQ-020 Overlap: z SHALL stay high while further equal samples arrive (run saturates at RUN_LEN, never wraps).
REQ-021 Polarity flip while z=1: z SHALL drop after that edge (run=1); an opposite-polarity run needs RUN_LEN fresh samples.
REQ-022 Mode change SHALL affect z in the same cycle with no state change.
REQ-023 det_count SHALL increment by 1 on an edge where en=1, run==RUN_LEN-1, w==last, and mode allows polarity w; it SHALL saturate at 2^CNT_W-1.
REQ-024 Mode change that raises z on an already-saturated run SHALL NOT increment det_count.

Reset
REQ-025 reset=1 at a clk edge SHALL force run=0, last=0, det_count=0, hence z=0, run_len=0, last_bit=0; reset has priority over en.
REQ-026 Reset mid-run SHALL discard the run; the next detection needs RUN_LEN fresh samples.

Configuration
REQ-027 Macro RUN_DETECTOR_COUNT_EN defined: det_count port and counter SHALL exist per REQ-023; undefined: port SHALL be absent and no counter logic synthesised, all other behaviour identical.

Structure
REQ-028 Package run_detector_pkg SHALL hold the mode encodings (MODE_BOTH, MODE_ONES, MODE_ZEROS, MODE_BOTH_ALT) and the default RUN_LEN/CNT_W constants.
REQ-029 Saturating run counter SHALL be a sub-module run_counter (params WIDTH, MAX; inputs clk, reset, inc, clr); state registers SHALL use the team's dff cell with Default 1'b0.

Verification (RUN_LEN=4, CNT_W=8)
REQ-030 mode=00, en=1, w=1,1,1,1 -> z=0 after edges 1-3, z=1 after edge 4, run_len=4, det_count=1.
REQ-031 mode=00, w=0,0,0,0,0,0,1 -> z=1 after edges 4-6, z=0 after edge 7, run_len=1, det_count=1.
REQ-032 mode=01, w=0x4 then 1x4 -> z=0 throughout zeros, z=1 after 8th edge, det_count=1; then mode=10 -> z=0 same cycle.
REQ-033 w=1,1,1 with en=0 for 5 cycles, then en=1 w=1 -> z=1 after the resumed edge only; run_len holds 3 while en=0.
REQ-034 w=1,1,1, reset=1 for one edge (en=1, w=1), then w=1,1,1 -> z=0 throughout, run_len=3, det_count=0.
REQ-035 CNT_W=2, 5 separate ones-runs of 4 -> det_count=3 (saturated); build without RUN_DETECTOR_COUNT_EN -> z identical.

Source files
------------

// File: rtl/run_detector_pkg.sv
`default_nettype none
// ============================================================================
// Module      : run_detector_pkg
// Description : Mode encodings, default sizing and polarity helper shared by
//               the run detector and its bench.
// Revision    : 1.0  initial release
// ============================================================================
package run_detector_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_BOTH     = 2'b00;
    localparam mode_t MODE_ONES     = 2'b01;
    localparam mode_t MODE_ZEROS    = 2'b10;
    localparam mode_t MODE_BOTH_ALT = 2'b11;

    localparam int RUN_LEN_DEFAULT = 4;
    localparam int CNT_W_DEFAULT   = 8;

    // True when a run of polarity b is allowed to raise z under mode m.
    function automatic logic mode_allows(input mode_t m, input logic b);
        case (m)
            MODE_ONES:  return b;
            MODE_ZEROS: return ~b;
            default:    return 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module      : dff
// Description : Generic register cell, synchronous active-high reset to a
//               replicated DEFAULT bit.
// Revision    : 1.0  initial release
// ============================================================================
module dff #(
    parameter int   WIDTH   = 1,
    parameter logic DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= {WIDTH{DEFAULT}};
        end else begin
            q <= d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/run_detector_run_counter.sv
`default_nettype none
// ============================================================================
// Module      : run_counter
// Description : Saturating up-counter (0..MAX). clr restarts the count, and
//               a simultaneous inc makes that restart count as the first step.
// Revision    : 1.0  initial release
// ============================================================================
module run_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = count;
        if (clr) begin
            w_next = inc ? c_one : '0;
        end else if (inc && (count != c_max)) begin
            w_next = count + c_one;
        end
    end

    dff #(.WIDTH(WIDTH), .DEFAULT(1'b0)) u_count (
        .clk   (clk),
        .reset (reset),
        .d     (w_next),
        .q     (count)
    );

endmodule
`default_nettype wire

// File: rtl/run_detector.sv
`default_nettype none
// ============================================================================
// Module      : run_detector
// Description : Flags runs of RUN_LEN equal qualified samples of w, with
//               polarity filtering by mode. Optional detection counter is
//               built when RUN_DETECTOR_COUNT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
module run_detector
    import run_detector_pkg::*;
#(
    parameter  int RUN_LEN = RUN_LEN_DEFAULT,
    parameter  int CNT_W   = CNT_W_DEFAULT,
    localparam int RL_W    = $clog2(RUN_LEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic            w,
    input  logic [1:0]      mode,
    output logic            z,
    output logic [RL_W-1:0] run_len,
    output logic            last_bit
`ifdef RUN_DETECTOR_COUNT_EN
    ,
    output logic [CNT_W-1:0] det_count
`endif
);

    generate
        if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
            $error("run_detector: RUN_LEN out of range 2..255");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("run_detector: CNT_W out of range 1..32");
        end
    endgenerate

    localparam logic [RL_W-1:0] c_run_max = RL_W'(RUN_LEN);
    localparam logic [RL_W-1:0] c_run_pre = RL_W'(RUN_LEN - 1);

    logic [RL_W-1:0] w_run;
    logic            w_last;
    logic            w_last_next;
    logic            w_active;
    logic            w_match;
    logic            w_clr;

    assign w_active    = (w_run != '0);
    assign w_match     = w_active && (w == w_last);
    // A differing sample restarts the run at 1; the first sample after reset
    // reaches 1 through the plain increment from 0.
    assign w_clr       = en && w_active && !w_match;
    assign w_last_next = en ? w : w_last;

    run_counter #(.WIDTH(RL_W), .MAX(RUN_LEN)) u_run (
        .clk   (clk),
        .reset (reset),
        .inc   (en),
        .clr   (w_clr),
        .count (w_run)
    );

    dff #(.WIDTH(1), .DEFAULT(1'b0)) u_last (
        .clk   (clk),
        .reset (reset),
        .d     (w_last_next),
        .q     (w_last)
    );

    assign z        = (w_run == c_run_max) && mode_allows(mode, w_last);
    assign run_len  = w_run;
    assign last_bit = w_last;

`ifdef RUN_DETECTOR_COUNT_EN
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic             w_det;
    logic [CNT_W-1:0] w_det_cnt;
    logic [CNT_W-1:0] w_det_cnt_next;

    // Counts only the edge that completes a run, so a later mode change that
    // exposes an already saturated run does not count again.
    assign w_det          = en && w_match && (w_run == c_run_pre) && mode_allows(mode, w);
    assign w_det_cnt_next = (w_det && (w_det_cnt != c_cnt_max)) ? (w_det_cnt + c_cnt_one)
                                                                : w_det_cnt;

    dff #(.WIDTH(CNT_W), .DEFAULT(1'b0)) u_det_cnt (
        .clk   (clk),
        .reset (reset),
        .d     (w_det_cnt_next),
        .q     (w_det_cnt)
    );

    assign det_count = w_det_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_run_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_detector
// Description : Table-driven directed bench for run_detector (RUN_LEN=4).
// Revision    : 1.0  initial release
// ============================================================================
module tb_run_detector;
    import run_detector_pkg::*;

    localparam int RL  = 4;
    localparam int RLW = $clog2(RL + 1);

    logic           clk = 1'b0;
    logic           reset;
    logic           en;
    logic           w;
    logic [1:0]     mode;
    logic           z, lb, z2, lb2;
    logic [RLW-1:0] rl, rl2;
`ifdef RUN_DETECTOR_COUNT_EN
    logic [7:0]     dc;
    logic [1:0]     dc2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    run_detector #(.RUN_LEN(RL), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .w        (w),
        .mode     (mode),
        .z        (z),
        .run_len  (rl),
        .last_bit (lb)
`ifdef RUN_DETECTOR_COUNT_EN
        ,
        .det_count(dc)
`endif
    );

    run_detector #(.RUN_LEN(RL), .CNT_W(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .w        (w),
        .mode     (mode),
        .z        (z2),
        .run_len  (rl2),
        .last_bit (lb2)
`ifdef RUN_DETECTOR_COUNT_EN
        ,
        .det_count(dc2)
`endif
    );

    typedef struct {
        logic       clk_edge;
        logic       rst;
        logic       en;
        logic       w;
        logic [1:0] mode;
        logic       z;
        int         rl;
        logic       lb;
        int         dc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic r, input logic n, input logic b,
                       input logic [1:0] m, input logic ez, input int erl,
                       input logic elb, input int edc);
        vec_t v;
        v.clk_edge = e; v.rst = r; v.en = n; v.w = b; v.mode = m;
        v.z = ez; v.rl = erl; v.lb = elb; v.dc = edc;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic r, input logic n, input logic b,
                         input logic [1:0] m);
        @(negedge clk);
        reset = r; en = n; w = b; mode = m;
        if (e) begin
            @(posedge clk);
            #1;
        end else begin
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; w = 1'b0; mode = MODE_BOTH;

        // reset state
        add(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        // four ones, mode both
        add(1, 0, 1, 1, 2'b00, 0, 1, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 2, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 3, 1, 0);
        add(1, 0, 1, 1, 2'b00, 1, 4, 1, 1);
        // reset wins over en
        add(1, 1, 1, 1, 2'b00, 0, 0, 0, 0);
        // six zeros then a one: saturation and polarity flip
        add(1, 0, 1, 0, 2'b00, 0, 1, 0, 0);
        add(1, 0, 1, 0, 2'b00, 0, 2, 0, 0);
        add(1, 0, 1, 0, 2'b00, 0, 3, 0, 0);
        add(1, 0, 1, 0, 2'b00, 1, 4, 0, 1);
        add(1, 0, 1, 0, 2'b00, 1, 4, 0, 1);
        add(1, 0, 1, 0, 2'b00, 1, 4, 0, 1);
        add(1, 0, 1, 1, 2'b00, 0, 1, 1, 1);
        add(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        // ones-only mode: zero run ignored, ones run detected
        add(1, 0, 1, 0, 2'b01, 0, 1, 0, 0);
        add(1, 0, 1, 0, 2'b01, 0, 2, 0, 0);
        add(1, 0, 1, 0, 2'b01, 0, 3, 0, 0);
        add(1, 0, 1, 0, 2'b01, 0, 4, 0, 0);
        add(1, 0, 1, 1, 2'b01, 0, 1, 1, 0);
        add(1, 0, 1, 1, 2'b01, 0, 2, 1, 0);
        add(1, 0, 1, 1, 2'b01, 0, 3, 1, 0);
        add(1, 0, 1, 1, 2'b01, 1, 4, 1, 1);
        // mode changes act combinationally, never re-count a saturated run
        add(0, 0, 0, 1, 2'b10, 0, 4, 1, 1);
        add(1, 0, 1, 1, 2'b10, 0, 4, 1, 1);
        add(1, 0, 1, 1, 2'b01, 1, 4, 1, 1);
        add(0, 0, 0, 1, 2'b00, 1, 4, 1, 1);
        add(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        // en=0 holds the run; w is ignored while disabled
        add(1, 0, 1, 1, 2'b00, 0, 1, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 2, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 3, 1, 0);
        add(1, 0, 0, 0, 2'b00, 0, 3, 1, 0);
        add(1, 0, 0, 1, 2'b00, 0, 3, 1, 0);
        add(1, 0, 0, 0, 2'b00, 0, 3, 1, 0);
        add(1, 0, 0, 1, 2'b00, 0, 3, 1, 0);
        add(1, 0, 0, 0, 2'b00, 0, 3, 1, 0);
        add(1, 0, 1, 1, 2'b00, 1, 4, 1, 1);
        add(1, 0, 0, 0, 2'b00, 1, 4, 1, 1);
        add(1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        // reset mid-run discards progress
        add(1, 0, 1, 1, 2'b00, 0, 1, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 2, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 3, 1, 0);
        add(1, 1, 1, 1, 2'b00, 0, 0, 0, 0);
        add(1, 0, 1, 1, 2'b00, 0, 1, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 2, 1, 0);
        add(1, 0, 1, 1, 2'b00, 0, 3, 1, 0);
        add(1, 0, 1, 1, 2'b11, 1, 4, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].clk_edge, vecs[i].rst, vecs[i].en, vecs[i].w, vecs[i].mode);
            chk("z", i, 32'(z), 32'(vecs[i].z));
            chk("run_len", i, 32'(rl), vecs[i].rl);
            chk("last_bit", i, 32'(lb), 32'(vecs[i].lb));
            chk("z_cntw2", i, 32'(z2), 32'(vecs[i].z));
            chk("run_len_cntw2", i, 32'(rl2), vecs[i].rl);
            chk("last_bit_cntw2", i, 32'(lb2), 32'(vecs[i].lb));
`ifdef RUN_DETECTOR_COUNT_EN
            chk("det_count", i, 32'(dc), vecs[i].dc);
            chk("det_count_cntw2", i, 32'(dc2), vecs[i].dc);
`endif
        end

        // five separate ones-runs: narrow counter saturates at 3
        drive(1, 1, 0, 0, 2'b01);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < RL; k++) begin
                drive(1, 0, 1, 1, 2'b01);
            end
            chk("sat_run_z", r, 32'(z), 32'd1);
            chk("sat_run_z_cntw2", r, 32'(z2), 32'd1);
            drive(1, 0, 1, 0, 2'b01);
            chk("sat_gap_z", r, 32'(z), 32'd0);
            chk("sat_gap_z_cntw2", r, 32'(z2), 32'd0);
        end
`ifdef RUN_DETECTOR_COUNT_EN
        chk("sat_det_count", 0, 32'(dc), 32'd5);
        chk("sat_det_count_cntw2", 0, 32'(dc2), 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
